gcd_dispatch: RTL and testbench
===============================

// Module: gcd_dispatch
// PURPOSE
//  Upstream job dispatcher for the 32-bit subtractive GCD core. Buffers tagged
//  operand pairs in a FIFO, issues them to the core one at a time via its
//  start/a/b interface, captures result on done, and presents tagged results
//  on a valid/ready output port. Strictly in-order, one job in flight.
// PARAMETERS
//  DEPTH   4    input FIFO entries; power of two, >= 2
//  TAG_W   4    width of the job tag carried alongside each operand pair
//  DATA_W  32   operand/result width; must equal the core width (32)
// PORTS
//  clk          in   1       clock
//  reset        in   1       asynchronous, active-high reset
//  in_valid     in   1       operand pair offered
//  in_ready     out  1       FIFO can accept (= count < DEPTH)
//  in_a         in   DATA_W  operand a
//  in_b         in   DATA_W  operand b
//  in_tag       in   TAG_W   job tag, returned with the result
//  core_start   out  1       start pulse to GCD core
//  core_a       out  DATA_W  operand a to core
//  core_b       out  DATA_W  operand b to core
//  core_result  in   DATA_W  GCD core result
//  core_done    in   1       GCD core done level
//  out_valid    out  1       result available
//  out_ready    in   1       consumer accepts result
//  out_result   out  DATA_W  GCD of the job
//  out_tag      out  TAG_W   tag of the job
//  busy         out  1       state != IDLE or FIFO non-empty
//  fifo_count   out  log2(DEPTH)+1  FIFO occupancy
//  job_count    out  16      completed jobs (out handshakes), wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, core_start=0, core_a/b=0, out_valid=0,
//   out_result=0, out_tag=0, job_count=0; in_ready=1. Reset mid-job aborts it;
//   no partial result is ever presented. Core shares the same reset.
//  FIFO: push on in_valid&&in_ready; in_ready from registered count only, so
//   push is rejected when full even if a pop occurs that cycle. Simultaneous
//   push+pop leaves count unchanged. Pointers wrap modulo DEPTH.
//  FSM:
//   IDLE : if FIFO non-empty -> pop head, register core_a/b + tag, go ISSUE.
//   ISSUE: core_start=1 for exactly this one cycle -> WAIT.
//   WAIT : core_start=0; when core_done=1 capture core_result into out_result,
//          tag into out_tag, set out_valid -> HOLD. (core_done is already 0
//          in the first WAIT cycle; no stale-done filtering needed.)
//   HOLD : out_valid=1, out_result/out_tag stable; on out_ready -> clear
//          out_valid, job_count+1, go IDLE. No new issue while in HOLD.
//  core_start is a decode of state ISSUE; core_a/b hold their value until the
//   next IDLE->ISSUE transition.
//  Latency: job pushed at cycle 0 into empty/idle block -> pop at end of cycle
//   1, core_start high in cycle 2; out_valid rises the cycle after core_done.
//  Zero operands passed through unmodified; core defines gcd(x,0)=x, (0,0)=0.
// TESTING
//  1. reset, push (a=12,b=18,tag=3) at cycle 0 -> core_start only in cycle 2;
//     out_valid with out_result=6, out_tag=3; job_count=1 after handshake.
//  2. out_ready=1, push 6 jobs back-to-back (tags 0..5) -> in_ready drops once
//     fifo_count=4; all 6 results return in tag order with correct GCDs.
//  3. hold out_ready=0 for 20 cycles after out_valid -> result/tag stable,
//     core_start stays 0, FIFO keeps accepting until full.
//  4. jobs (0,7),(7,0),(0,0),(1,0xFFFFFFFF) -> results 7,7,0,1.
//  5. assert reset during WAIT with 2 jobs queued -> next cycle out_valid=0,
//     fifo_count=0, in_ready=1, job_count=0; fresh job (48,36) -> 12.
//  6. FIFO full, in_valid=1 in the cycle a pop occurs -> not accepted that
//     cycle (in_ready=0); accepted next cycle, fifo_count back to 4.

Source files
------------

// File: rtl/gcd_dispatch.sv
// rtl/gcd_dispatch.sv - in-order tagged job dispatcher feeding a 32-bit GCD core
module gcd_dispatch #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_a,
    input  logic [DATA_W-1:0]        in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     core_start,
    output logic [DATA_W-1:0]        core_a,
    output logic [DATA_W-1:0]        core_b,
    input  logic [DATA_W-1:0]        core_result,
    input  logic                     core_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_result,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              job_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  mem_a   [DEPTH];
    logic [DATA_W-1:0]  mem_b   [DEPTH];
    logic [TAG_W-1:0]   mem_tag [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [TAG_W-1:0]   job_tag;
    logic               push;
    logic               pop;

    // Readiness comes from the registered count only: a same-cycle pop never frees a slot early.
    assign in_ready   = (count < CNT_W'(DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = (state == IDLE) && (count != '0);
    assign busy       = (state != IDLE) || (count != '0);
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]   <= in_a;
            mem_b[wr_ptr]   <= in_b;
            mem_tag[wr_ptr] <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            core_start <= 1'b0;
            core_a     <= '0;
            core_b     <= '0;
            job_tag    <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            job_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        core_a     <= mem_a[rd_ptr];
                        core_b     <= mem_b[rd_ptr];
                        job_tag    <= mem_tag[rd_ptr];
                        core_start <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    core_start <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        out_result <= core_result;
                        out_tag    <= job_tag;
                        out_valid  <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        job_count <= job_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    core_start <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_dispatch.sv
// tb/tb_gcd_dispatch.sv - directed and randomized bench for gcd_dispatch with a behavioural core
module tb_gcd_dispatch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [3:0]  in_tag = '0;
    logic        core_start;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic [31:0] core_result;
    logic        core_done;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic        busy;
    logic [2:0]  fifo_count;
    logic [15:0] job_count;

    gcd_dispatch #(.DEPTH(4), .TAG_W(4), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .core_start(core_start), .core_a(core_a), .core_b(core_b),
        .core_result(core_result), .core_done(core_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
        .busy(busy), .fifo_count(fifo_count), .job_count(job_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  tag;
    } job_t;

    job_t exp_q[$];
    job_t got_q[$];
    int   total = 0;
    int   passed = 0;
    int   hs_count = 0;
    int   core_lat = 3;
    int   core_cnt;
    logic full_seen = 1'b0;
    logic full_ready_bad = 1'b0;

    function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Behavioural core: done is a level cleared by start and raised after a latency.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            core_done   <= 1'b0;
            core_result <= '0;
            core_cnt    <= 0;
        end else if (core_start) begin
            core_done   <= 1'b0;
            core_result <= gcd_ref(core_a, core_b);
            core_cnt    <= (core_lat == 0) ? int'($urandom_range(1, 6)) : core_lat;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) core_done <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (in_valid && in_ready) exp_q.push_back({gcd_ref(in_a, in_b), in_tag});
            if (out_valid && out_ready) begin
                got_q.push_back({out_result, out_tag});
                hs_count++;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && fifo_count == 3'd4) begin
            full_seen = 1'b1;
            if (in_ready) full_ready_bad = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                        input bit rnd_ready);
        int g = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        while (!in_ready && g < 500) begin
            step();
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            g++;
        end
        chk("push_timeout", 64'(g < 500), 64'd1);
        step();
    endtask

    task automatic wait_out(input string name);
        int g = 0;
        while (!out_valid && g < 500) begin
            step();
            g++;
        end
        chk(name, 64'(out_valid), 64'd1);
    endtask

    task automatic drain(input string name);
        int   g = 0;
        job_t e, o;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((busy || got_q.size() < exp_q.size()) && g < 3000) begin
            step();
            g++;
        end
        chk({name, "_drain_done"}, 64'(g < 3000), 64'd1);
        chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            o = got_q.pop_front();
            chk({name, "_result"}, 64'(o.res), 64'(e.res));
            chk({name, "_tag"}, 64'(o.tag), 64'(e.tag));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] za[4];
        logic [31:0] zb[4];
        logic [31:0] zr[4];
        logic [31:0] ra, rb;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_core_start", 64'(core_start), 64'd0);
        chk("rst_core_a", 64'(core_a), 64'd0);
        chk("rst_core_b", 64'(core_b), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_job_count", 64'(job_count), 64'd0);
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        step();

        // Single job latency: core_start only in cycle 2.
        core_lat = 3;
        in_valid = 1'b1; in_a = 32'd12; in_b = 32'd18; in_tag = 4'd3;
        chk("t1_c0_start", 64'(core_start), 64'd0);
        step();
        in_valid = 1'b0;
        chk("t1_c1_start", 64'(core_start), 64'd0);
        chk("t1_c1_count", 64'(fifo_count), 64'd1);
        step();
        chk("t1_c2_start", 64'(core_start), 64'd1);
        chk("t1_c2_core_a", 64'(core_a), 64'd12);
        chk("t1_c2_core_b", 64'(core_b), 64'd18);
        chk("t1_c2_count", 64'(fifo_count), 64'd0);
        step();
        chk("t1_c3_start", 64'(core_start), 64'd0);
        wait_out("t1_out_valid");
        chk("t1_result", 64'(out_result), 64'd6);
        chk("t1_tag", 64'(out_tag), 64'd3);
        chk("t1_job_count_pre", 64'(job_count), 64'd0);
        out_ready = 1'b1;
        step();
        chk("t1_out_valid_clr", 64'(out_valid), 64'd0);
        chk("t1_job_count", 64'(job_count), 64'd1);
        drain("t1");

        // Back-to-back burst fills the FIFO.
        core_lat = 4;
        out_ready = 1'b1;
        full_seen = 1'b0;
        full_ready_bad = 1'b0;
        for (int i = 0; i < 6; i++)
            push(32'($urandom_range(1, 1000)) * 32'd6, 32'($urandom_range(1, 1000)) * 32'd4, 4'(i), 1'b0);
        in_valid = 1'b0;
        chk("t2_full_seen", 64'(full_seen), 64'd1);
        chk("t2_ready_when_full", 64'(full_ready_bad), 64'd0);
        drain("t2");

        // Output back-pressure: result stable, no new issue, FIFO fills.
        core_lat = 0;
        out_ready = 1'b0;
        push(32'd84, 32'd60, 4'd9, 1'b0);
        in_valid = 1'b0;
        wait_out("t3_out_valid");
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_a = 32'($urandom_range(1, 5000));
            in_b = 32'($urandom_range(1, 5000));
            in_tag = 4'(i);
            step();
            chk("t3_hold_valid", 64'(out_valid), 64'd1);
            chk("t3_hold_result", 64'(out_result), 64'd12);
            chk("t3_hold_tag", 64'(out_tag), 64'd9);
            chk("t3_hold_no_start", 64'(core_start), 64'd0);
        end
        in_valid = 1'b0;
        chk("t3_fifo_full", 64'(fifo_count), 64'd4);
        chk("t3_in_ready_low", 64'(in_ready), 64'd0);

        // Push offered in the same cycle as a pop from a full FIFO.
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 32'd100; in_b = 32'd75; in_tag = 4'd14;
        step();
        out_ready = 1'b0;
        chk("t6_pop_cycle_ready", 64'(in_ready), 64'd0);
        chk("t6_pop_cycle_count", 64'(fifo_count), 64'd4);
        step();
        chk("t6_next_ready", 64'(in_ready), 64'd1);
        chk("t6_next_count", 64'(fifo_count), 64'd3);
        step();
        in_valid = 1'b0;
        chk("t6_refilled", 64'(fifo_count), 64'd4);
        drain("t36");

        // Zero and extreme operands.
        za[0] = 32'd0; zb[0] = 32'd7;          zr[0] = 32'd7;
        za[1] = 32'd7; zb[1] = 32'd0;          zr[1] = 32'd7;
        za[2] = 32'd0; zb[2] = 32'd0;          zr[2] = 32'd0;
        za[3] = 32'd1; zb[3] = 32'hFFFF_FFFF;  zr[3] = 32'd1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(za[i], zb[i], 4'(i), 1'b0);
            in_valid = 1'b0;
            out_ready = 1'b0;
            wait_out("t4_out_valid");
            chk("t4_result", 64'(out_result), 64'(zr[i]));
            chk("t4_tag", 64'(out_tag), 64'(i));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        drain("t4");

        // Reset while a job is in flight with two more queued.
        core_lat = 20;
        out_ready = 1'b1;
        push(32'd30, 32'd45, 4'd1, 1'b0);
        push(32'd22, 32'd33, 4'd2, 1'b0);
        push(32'd14, 32'd21, 4'd3, 1'b0);
        in_valid = 1'b0;
        step();
        step();
        chk("t5_queued", 64'(fifo_count), 64'd2);
        chk("t5_waiting", 64'(out_valid), 64'd0);
        reset = 1'b1;
        #2;
        exp_q.delete();
        got_q.delete();
        hs_count = 0;
        step();
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_fifo_count", 64'(fifo_count), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        chk("t5_job_count", 64'(job_count), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        step();
        core_lat = 0;
        push(32'd48, 32'd36, 4'd5, 1'b0);
        in_valid = 1'b0;
        out_ready = 1'b0;
        wait_out("t5_out_valid_new");
        chk("t5_result", 64'(out_result), 64'd12);
        chk("t5_tag", 64'(out_tag), 64'd5);
        drain("t5");
        chk("t5_job_count_after", 64'(job_count), 64'd1);

        // Randomized jobs under random back-pressure and core latency.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: begin ra = 32'($urandom_range(0, 3)); rb = $urandom; end
                1: begin ra = $urandom; rb = $urandom; end
                default: begin
                    ra = 32'($urandom_range(1, 4000)) * 32'($urandom_range(1, 50));
                    rb = 32'($urandom_range(1, 4000)) * 32'($urandom_range(1, 50));
                end
            endcase
            out_ready = 1'($urandom_range(0, 1));
            push(ra, rb, 4'($urandom), 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                step();
            end
        end
        drain("rnd");
        chk("final_job_count", 64'(job_count), 64'(hs_count[15:0]));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
